// File: rtl/palette_lut_ram.sv
// Multi-bank runtime-writable colour palette with a 2-cycle lookup pipeline; self-loads a grey ramp after reset.
// Optional build macro PALETTE_FADE_EN adds a fade_lvl input that scales every channel at the output stage.
module palette_lut_ram #(
  parameter int IDX_W      = 4,
  parameter int CH_W       = 4,
  parameter int NUM_BANKS  = 4,
  parameter int TRANSP_IDX = 0,
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                pix_valid,
  input  logic [IDX_W-1:0]    pix_index,
  input  logic [BANK_W-1:0]   pix_bank,
  output logic [CH_W-1:0]     red,
  output logic [CH_W-1:0]     green,
  output logic [CH_W-1:0]     blue,
  output logic                out_valid,
  output logic                transparent,
  input  logic                wr_en,
  input  logic [BANK_W-1:0]   wr_bank,
  input  logic [IDX_W-1:0]    wr_addr,
  input  logic [3*CH_W-1:0]   wr_data,
`ifdef PALETTE_FADE_EN
  input  logic [CH_W-1:0]     fade_lvl,
`endif
  output logic                wr_ready,
  output logic                init_busy
);

  localparam int AW    = BANK_W + IDX_W;
  localparam int DEPTH = NUM_BANKS * (2 ** IDX_W);
  localparam int RGB_W = 3 * CH_W;
  localparam logic [AW-1:0]     LAST_ENTRY = AW'(DEPTH - 1);
  localparam logic [AW-1:0]     ONE_AW     = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [BANK_W:0]   NB         = (BANK_W+1)'(NUM_BANKS);
  localparam logic [IDX_W-1:0]  TIDX       = IDX_W'(TRANSP_IDX);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            state_r, state_s;
  logic [AW-1:0]     sweep_cnt_r;
  logic [RGB_W-1:0]  mem_r [0:DEPTH-1];
  logic              mem_we_s;
  logic [AW-1:0]     mem_addr_s;
  logic [RGB_W-1:0]  mem_data_s;
  logic              bank_ok_s;
  logic              s1_valid_r, s1_transp_r;
  logic [RGB_W-1:0]  s1_rgb_r;
  logic [CH_W-1:0]   red_s, green_s, blue_s;

  // Ramp value: the index left-aligned into a channel (top bits of {addr, zeros}).
  function automatic logic [CH_W-1:0] ramp_ch(input logic [IDX_W-1:0] addr);
    logic [IDX_W+CH_W-1:0] ext;
    ext = {addr, {CH_W{1'b0}}};
    return ext[IDX_W+CH_W-1 -: CH_W];
  endfunction

  // Sweep FSM next-state
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (sweep_cnt_r == LAST_ENTRY) state_s = ST_RUN;
        else                           state_s = ST_INIT;
      end
      ST_RUN:  state_s = ST_RUN;
      default: state_s = ST_INIT;
    endcase
  end

  // State, sweep counter and status flags
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r     <= ST_INIT;
      sweep_cnt_r <= '0;
      init_busy   <= 1'b1;
      wr_ready    <= 1'b0;
    end else begin
      state_r <= state_s;
      if (state_r == ST_INIT) sweep_cnt_r <= sweep_cnt_r + ONE_AW;
      init_busy <= (state_s == ST_INIT);
      wr_ready  <= (state_s == ST_RUN);
    end
  end

  // Single RAM write port shared by the init sweep and runtime writes
  always_comb begin
    mem_we_s   = 1'b0;
    mem_addr_s = '0;
    mem_data_s = '0;
    if (Reset) begin
      mem_we_s = 1'b0;
    end else if (state_r == ST_INIT) begin
      mem_we_s   = 1'b1;
      mem_addr_s = sweep_cnt_r;
      mem_data_s = {3{ramp_ch(sweep_cnt_r[IDX_W-1:0])}};
    end else if (wr_en && wr_ready && ({1'b0, wr_bank} < NB)) begin
      mem_we_s   = 1'b1;
      mem_addr_s = {wr_bank, wr_addr};
      mem_data_s = wr_data;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Palette storage (no reset; contents come from the sweep)
  always_ff @(posedge Clk) begin
    if (mem_we_s) mem_r[mem_addr_s] <= mem_data_s;
  end

  assign bank_ok_s = ({1'b0, pix_bank} < NB);

`ifdef PALETTE_FADE_EN
  logic [CH_W-1:0] s1_fade_r;

  function automatic logic [CH_W-1:0] fade_ch(input logic [CH_W-1:0] ch, input logic [CH_W-1:0] lvl);
    logic [2*CH_W-1:0] prod;
    prod = {{CH_W{1'b0}}, ch} * ({{CH_W{1'b0}}, lvl} + {{(2*CH_W-1){1'b0}}, 1'b1});
    return prod[2*CH_W-1:CH_W];
  endfunction

  // Fade level travels alongside stage 1
  always_ff @(posedge Clk) begin
    if (Reset) s1_fade_r <= '0;
    else       s1_fade_r <= fade_lvl;
  end

  assign red_s   = fade_ch(s1_rgb_r[3*CH_W-1 -: CH_W], s1_fade_r);
  assign green_s = fade_ch(s1_rgb_r[2*CH_W-1 -: CH_W], s1_fade_r);
  assign blue_s  = fade_ch(s1_rgb_r[CH_W-1:0], s1_fade_r);
`else
  assign red_s   = s1_rgb_r[3*CH_W-1 -: CH_W];
  assign green_s = s1_rgb_r[2*CH_W-1 -: CH_W];
  assign blue_s  = s1_rgb_r[CH_W-1:0];
`endif

  // Stage 1: read-first RAM read; a same-edge write is not visible here
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid_r  <= 1'b0;
      s1_transp_r <= 1'b0;
      s1_rgb_r    <= '0;
    end else begin
      s1_valid_r  <= pix_valid && (state_r == ST_RUN);
      s1_transp_r <= !bank_ok_s || (pix_index == TIDX);
      s1_rgb_r    <= bank_ok_s ? mem_r[{pix_bank, pix_index}] : '0;
    end
  end

  // Stage 2: output registers; colours hold while no lookup completes
  always_ff @(posedge Clk) begin
    if (Reset) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      out_valid   <= 1'b0;
      transparent <= 1'b0;
    end else begin
      out_valid   <= s1_valid_r;
      transparent <= s1_valid_r && s1_transp_r;
      if (s1_valid_r) begin
        red   <= red_s;
        green <= green_s;
        blue  <= blue_s;
      end
    end
  end

endmodule

// File: tb/tb_palette_lut_ram.sv
// Bench for palette_lut_ram: directed scenarios plus random traffic checked against an array-based palette model.
module tb_palette_lut_ram;
  localparam int IDX_W = 4, CH_W = 4, NUM_BANKS = 4, TRANSP_IDX = 0;
  localparam int BANK_W = 2, ENTRIES = 16, DEPTH = 64, MAXC = 4096;

  logic Clk = 1'b0, Reset = 1'b1;
  logic pix_valid = 1'b0, wr_en = 1'b0;
  logic [IDX_W-1:0] pix_index = '0, wr_addr = '0;
  logic [BANK_W-1:0] pix_bank = '0, wr_bank = '0;
  logic [11:0] wr_data = '0;
  logic [CH_W-1:0] red, green, blue;
  logic out_valid, transparent, wr_ready, init_busy;
`ifdef PALETTE_FADE_EN
  logic [CH_W-1:0] fade_lvl = 4'hF;
`endif

  palette_lut_ram dut (
    .Clk(Clk), .Reset(Reset), .pix_valid(pix_valid), .pix_index(pix_index), .pix_bank(pix_bank),
    .red(red), .green(green), .blue(blue), .out_valid(out_valid), .transparent(transparent),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef PALETTE_FADE_EN
    .fade_lvl(fade_lvl),
`endif
    .wr_ready(wr_ready), .init_busy(init_busy)
  );

  always #5 Clk = ~Clk;

  int vectors = 0, miscompares = 0, cyc = 0, init_left = 0;
  int nvalid = 0, ntransp = 0;
  logic [11:0] model [DEPTH];
  bit exp_valid [MAXC];
  bit exp_tr [MAXC];
  logic [11:0] exp_rgb [MAXC];
  logic [11:0] last_rgb = 12'h000;

  function automatic logic [3:0] ramp_val(input int addr);
    return 4'((addr * (1 << CH_W)) >> IDX_W);
  endfunction

  function automatic logic [11:0] faded(input logic [11:0] c, input int lvl);
    int r, g, b;
    r = (int'(c[11:8]) * (lvl + 1)) >> CH_W;
    g = (int'(c[7:4])  * (lvl + 1)) >> CH_W;
    b = (int'(c[3:0])  * (lvl + 1)) >> CH_W;
    return {4'(r), 4'(g), 4'(b)};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic reload();
    for (int i = 0; i < DEPTH; i++) model[i] = {3{ramp_val(i % ENTRIES)}};
  endtask

  task automatic tick();
    bit rst_now, run_before;
    int fl;
    rst_now = Reset;
    run_before = (init_left == 0);
    fl = 15;
`ifdef PALETTE_FADE_EN
    fl = int'(fade_lvl);
`endif
    if (cyc >= MAXC - 3) begin
      $display("FAIL cycle_budget: reached %0d of %0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    if (rst_now) begin
      exp_valid[cyc+1] = 1'b0;
      exp_valid[cyc+2] = 1'b0;
      reload();
      init_left = DEPTH;
    end else begin
      exp_valid[cyc+2] = run_before && pix_valid;
      if (int'(pix_bank) < NUM_BANKS) exp_rgb[cyc+2] = faded(model[int'(pix_bank)*ENTRIES + int'(pix_index)], fl);
      else exp_rgb[cyc+2] = 12'h000;
      exp_tr[cyc+2] = (int'(pix_bank) >= NUM_BANKS) || (int'(pix_index) == TRANSP_IDX);
      if (run_before && wr_en && int'(wr_bank) < NUM_BANKS) model[int'(wr_bank)*ENTRIES + int'(wr_addr)] = wr_data;
      if (init_left > 0) init_left--;
    end
    @(posedge Clk);
    #1;
    cyc++;
    if (exp_valid[cyc]) last_rgb = exp_rgb[cyc];
    else if (rst_now) last_rgb = 12'h000;
    if (out_valid === 1'b1) nvalid++;
    if (out_valid === 1'b1 && transparent === 1'b1) ntransp++;
    chk("out_valid", 16'(out_valid), 16'(exp_valid[cyc]));
    chk("rgb", 16'({red, green, blue}), 16'(last_rgb));
    if (exp_valid[cyc]) chk("transparent", 16'(transparent), 16'(exp_tr[cyc]));
    else if (rst_now) chk("transparent_rst", 16'(transparent), 16'h0000);
    chk("init_busy", 16'(init_busy), 16'(init_left > 0));
    chk("wr_ready", 16'(wr_ready), 16'(init_left == 0));
  endtask

  task automatic idle();
    pix_valid = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic lookup(input int bank, input int idx);
    pix_valid = 1'b1;
    pix_bank = BANK_W'(bank);
    pix_index = IDX_W'(idx);
  endtask

  task automatic write(input int bank, input int addr, input logic [11:0] data);
    wr_en = 1'b1;
    wr_bank = BANK_W'(bank);
    wr_addr = IDX_W'(addr);
    wr_data = data;
  endtask

  task automatic rand_inputs();
    logic [31:0] r, d;
    r = $urandom();
    d = $urandom();
    pix_valid = r[0];
    pix_index = r[4:1];
    pix_bank = r[6:5];
    wr_en = r[7] & r[8];
    wr_bank = r[10:9];
    wr_addr = r[14:11];
    wr_data = d[11:0];
    if (r[16:15] == 2'b00) begin
      wr_bank = pix_bank;
      wr_addr = pix_index;
    end
`ifdef PALETTE_FADE_EN
    fade_lvl = d[15:12];
`endif
  endtask

  initial begin
    reload();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    // Attempted writes and lookups during the sweep must be ignored
    write(0, 7, 12'h123);
    lookup(0, 7);
    repeat (DEPTH) tick();
    chk("init_done_ready", 16'(wr_ready), 16'h0001);
    idle();

    lookup(2, 9); tick(); idle(); tick();
    chk("t1_rgb", 16'({red, green, blue}), 16'h0999);
    chk("t1_valid", 16'(out_valid), 16'h0001);

    lookup(0, 7); tick(); idle(); tick();
    chk("t5_ignored_write", 16'({red, green, blue}), 16'h0777);

    write(1, 3, 12'hD39); tick(); idle();
    lookup(1, 3); tick();
    lookup(0, 3); tick();
    chk("t2_written", 16'({red, green, blue}), 16'h0D39);
    idle(); tick();
    chk("t2_other_bank", 16'({red, green, blue}), 16'h0333);

    write(0, 5, 12'hFFF); lookup(0, 5); tick();
    wr_en = 1'b0; tick();
    chk("t3_read_first", 16'({red, green, blue}), 16'h0555);
    idle(); tick();
    chk("t3_new_value", 16'({red, green, blue}), 16'h0FFF);
    tick();

    nvalid = 0; ntransp = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      lookup(3, i);
      tick();
    end
    idle(); tick(); tick();
    chk("t4_valid_count", 16'(nvalid), 16'd16);
    chk("t4_transp_count", 16'(ntransp), 16'd1);

`ifdef PALETTE_FADE_EN
    write(2, 4, 12'hF82); tick(); idle();
    lookup(2, 4); fade_lvl = 4'h7; tick();
    idle(); fade_lvl = 4'hF; tick();
    chk("t6_fade", 16'({red, green, blue}), 16'h0741);
`endif

    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      tick();
    end

    // Reset in the middle of traffic
    rand_inputs(); pix_valid = 1'b1; tick();
    rand_inputs(); pix_valid = 1'b1; Reset = 1'b1; tick();
    chk("t6_valid_after_rst", 16'(out_valid), 16'h0000);
    Reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rand_inputs();
      tick();
    end
    idle();
`ifdef PALETTE_FADE_EN
    fade_lvl = 4'hF;
`endif
    lookup(1, 3); tick(); idle(); tick();
    chk("t6_writes_lost", 16'({red, green, blue}), 16'h0333);

    for (int i = 0; i < 200; i++) begin
      rand_inputs();
      tick();
    end
    idle(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
